// File: rtl/pokey_controller_responder_if.sv
// Signal bundle between POKEY/host stimulus and the controller responder.
// master = POKEY plus host stimulus side, slave = the responder.
interface pokey_controller_responder_if;
  logic [3:0] key_scan_L;
  logic [3:0] key_code;
  logic       key_press;
  logic       key_release;
  logic       brk_held;
  logic       pot_rel_0;
  logic       pot_rel_1;
  logic [7:0] pot_val_0;
  logic [7:0] pot_val_1;
  logic       kr1_L;
  logic       kr2_L;
  logic [1:0] pot_scan;
  logic       key_held;

  modport master (
    output key_scan_L, key_code, key_press, key_release, brk_held,
           pot_rel_0, pot_rel_1, pot_val_0, pot_val_1,
    input  kr1_L, kr2_L, pot_scan, key_held
  );

  modport slave (
    input  key_scan_L, key_code, key_press, key_release, brk_held,
           pot_rel_0, pot_rel_1, pot_val_0, pot_val_1,
    output kr1_L, kr2_L, pot_scan, key_held
  );
endinterface

// File: rtl/pokey_controller_responder.sv
// 5200-style controller stand-in: answers POKEY key scans on kr1_L/kr2_L and
// fires each pot_scan line a programmed number of pot-counter steps after release.
//
// pot state  | meaning
// POT_DUMP   | line dumped, counters cleared, waiting for a low->high release
// POT_CHARGE | counting TICK_DIV clocks per step until step reaches target
// POT_FIRED  | threshold crossed, pot_scan held high, counters frozen
module pokey_controller_responder #(
  parameter int unsigned TICK_DIV = 114,
  parameter logic [7:0]  POT_MAX  = 8'd228
) (
  input logic                          clk,
  input logic                          n_reset,
  pokey_controller_responder_if.slave  bus
);

  typedef enum logic [1:0] {
    POT_DUMP   = 2'd0,
    POT_CHARGE = 2'd1,
    POT_FIRED  = 2'd2
  } pot_state_t;

  localparam logic [7:0] TICK_LAST = 8'(TICK_DIV - 1);

  logic [3:0] scan_code;
  logic [3:0] held_code;
  logic       key_held_q;
  logic       kr1_q;
  logic       kr2_q;

  logic [1:0] pot_rel;
  logic [7:0] pot_val   [2];
  logic [1:0] rel_prev;
  logic [1:0] pot_scan_q;
  pot_state_t pot_state [2];
  logic [7:0] tick      [2];
  logic [7:0] step      [2];
  logic [7:0] target    [2];

  assign scan_code  = ~bus.key_scan_L;
  assign pot_rel    = {bus.pot_rel_1, bus.pot_rel_0};
  assign pot_val[0] = bus.pot_val_0;
  assign pot_val[1] = bus.pot_val_1;

  assign bus.kr1_L    = kr1_q;
  assign bus.kr2_L    = kr2_q;
  assign bus.key_held = key_held_q;
  assign bus.pot_scan = pot_scan_q;

  // Release beats press in the same cycle and leaves the held code untouched.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      key_held_q <= 1'b0;
      held_code  <= 4'h0;
      kr1_q      <= 1'b1;
      kr2_q      <= 1'b1;
    end else begin
      if (bus.key_release) begin
        key_held_q <= 1'b0;
      end else if (bus.key_press) begin
        key_held_q <= 1'b1;
        held_code  <= bus.key_code;
      end
      kr1_q <= ~(key_held_q && (scan_code == held_code));
      kr2_q <= ~(bus.brk_held && (scan_code == 4'h0));
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      rel_prev   <= 2'b00;
      pot_scan_q <= 2'b00;
      for (int n = 0; n < 2; n++) begin
        pot_state[n] <= POT_DUMP;
        tick[n]      <= 8'd0;
        step[n]      <= 8'd0;
        target[n]    <= 8'd0;
      end
    end else begin
      rel_prev <= pot_rel;
      for (int n = 0; n < 2; n++) begin
        case (pot_state[n])
          POT_DUMP: begin
            pot_scan_q[n] <= 1'b0;
            tick[n]       <= 8'd0;
            step[n]       <= 8'd0;
            if (pot_rel[n] && !rel_prev[n]) begin
              pot_state[n] <= POT_CHARGE;
              target[n]    <= (pot_val[n] > POT_MAX) ? POT_MAX : pot_val[n];
            end
          end
          POT_CHARGE: begin
            if (!pot_rel[n]) begin
              pot_state[n]  <= POT_DUMP;
              pot_scan_q[n] <= 1'b0;
            end else if (step[n] >= target[n]) begin
              pot_state[n]  <= POT_FIRED;
              pot_scan_q[n] <= 1'b1;
            end else if (tick[n] == TICK_LAST) begin
              tick[n] <= 8'd0;
              if (step[n] != POT_MAX) begin
                step[n] <= step[n] + 8'd1;
              end
            end else begin
              tick[n] <= tick[n] + 8'd1;
            end
          end
          POT_FIRED: begin
            if (!pot_rel[n]) begin
              pot_state[n]  <= POT_DUMP;
              pot_scan_q[n] <= 1'b0;
            end else begin
              pot_scan_q[n] <= 1'b1;
            end
          end
          default: begin
            pot_state[n]  <= POT_DUMP;
            pot_scan_q[n] <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
